// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 5-stage core.
//
// Each cycle selects the next fetch address (sequential +4, ID-stage jump or
// EX-stage branch), drives the PC write enable and the IF/ID and ID/EX flush
// pulses. A redirect seen while the front end is stalled is parked and
// replayed on the first non-stall cycle.
//
// Optional feature: define PC_ALIGN_TRAP_EN to redirect misaligned targets to
// TRAP_VEC and pulse trap_o; otherwise target[1:0] is forced to 2'b00.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_cur_i          current PC register value
//   icache_stall_i    I-cache miss in progress
//   dcache_stall_i    D-cache miss in progress
//   hazard_i          load-use hazard
//   branch_taken_i    taken branch resolved in EX, target branch_target_i
//   jump_i            jal/jalr decoded in ID, target jump_target_i
//   pc_next_o         next PC value (combinational)
//   pc_write_o        PC register write enable (combinational)
//   flush_if_o        squash IF/ID (combinational)
//   flush_id_o        squash ID/EX (combinational)
//   trap_o            registered one-cycle misaligned-target pulse
//   redirect_cnt_o    registered saturating count of applied redirects
module pc_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_cur_i,
    input  logic        icache_stall_i,
    input  logic        dcache_stall_i,
    input  logic        hazard_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        trap_o,
    output logic [15:0] redirect_cnt_o
);

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_is_br_q, pend_is_br_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic        first_q;

    logic        stall;
    logic        apply;       // a redirect is loaded into the PC at the next edge
    logic [31:0] apply_tgt;   // raw (unchecked) target of that redirect
    logic [31:0] seq_next;    // pc_next_o when no redirect is applied
    logic [31:0] redirect_pc; // apply_tgt after alignment handling

    assign stall = icache_stall_i | dcache_stall_i | hazard_i;

    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        pend_is_br_d = pend_is_br_q;
        seq_next     = pc_cur_i;
        pc_write_o   = 1'b0;
        flush_if_o   = 1'b0;
        flush_id_o   = 1'b0;
        apply        = 1'b0;
        apply_tgt    = pc_cur_i;

        if (!rst_n) begin
            seq_next = RESET_PC;
        end else if (first_q) begin
            seq_next   = RESET_PC;
            pc_write_o = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (branch_taken_i) begin
                        flush_if_o = 1'b1;
                        flush_id_o = 1'b1;
                        apply_tgt  = branch_target_i;
                    end else if (jump_i) begin
                        flush_if_o = 1'b1;
                        apply_tgt  = jump_target_i;
                    end
                    if (!stall) begin
                        pc_write_o = 1'b1;
                        if (branch_taken_i || jump_i) begin
                            apply = 1'b1;
                        end else begin
                            seq_next = pc_cur_i + 32'd4;
                        end
                    end else if (branch_taken_i || jump_i) begin
                        pend_pc_d    = apply_tgt;
                        pend_is_br_d = branch_taken_i;
                        state_d      = ST_HOLD;
                    end
                end
                default: begin // ST_HOLD; jump_i is on the wrong path here
                    if (stall) begin
                        // Only an older (EX) branch may displace a parked jump.
                        if (branch_taken_i && !pend_is_br_q) begin
                            pend_pc_d    = branch_target_i;
                            pend_is_br_d = 1'b1;
                            flush_if_o   = 1'b1;
                            flush_id_o   = 1'b1;
                        end
                    end else begin
                        pc_write_o   = 1'b1;
                        apply        = 1'b1;
                        state_d      = ST_RUN;
                        pend_is_br_d = 1'b0;
                        if (branch_taken_i) begin
                            apply_tgt  = branch_target_i;
                            flush_if_o = 1'b1;
                            flush_id_o = 1'b1;
                        end else begin
                            apply_tgt = pend_pc_q;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PC_ALIGN_TRAP_EN
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic misaligned;
    logic trap_q;

    assign misaligned  = |apply_tgt[1:0];
    assign redirect_pc = misaligned ? TRAP_VEC : apply_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= apply & misaligned;
        end
    end

    assign trap_o = trap_q;
`else
    assign redirect_pc = apply_tgt & 32'hFFFF_FFFC;
    assign trap_o      = 1'b0;
`endif

    assign pc_next_o = apply ? redirect_pc : seq_next;

    assign redirect_cnt_d = (apply && (redirect_cnt_q != 16'hFFFF)) ?
                            redirect_cnt_q + 16'd1 : redirect_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            pend_pc_q      <= 32'h0;
            pend_is_br_q   <= 1'b0;
            redirect_cnt_q <= 16'h0;
            first_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            pend_pc_q      <= pend_pc_d;
            pend_is_br_q   <= pend_is_br_d;
            redirect_cnt_q <= redirect_cnt_d;
            first_q        <= 1'b0;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_cur_i = '0;
    logic        icache_stall_i = 1'b0, dcache_stall_i = 1'b0, hazard_i = 1'b0;
    logic        branch_taken_i = 1'b0, jump_i = 1'b0;
    logic [31:0] branch_target_i = '0, jump_target_i = '0;
    logic [31:0] pc_next_o;
    logic        pc_write_o, flush_if_o, flush_id_o, trap_o;
    logic [15:0] redirect_cnt_o;

    pc_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_cur_i       (pc_cur_i),
        .icache_stall_i (icache_stall_i),
        .dcache_stall_i (dcache_stall_i),
        .hazard_i       (hazard_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .pc_next_o      (pc_next_o),
        .pc_write_o     (pc_write_o),
        .flush_if_o     (flush_if_o),
        .flush_id_o     (flush_id_o),
        .trap_o         (trap_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: cycles since reset, an optional parked redirect,
    // expected counter/trap after the last edge, and the PC register.
    bit          m_first;
    bit          m_have_pend;
    logic [31:0] m_pend_tgt;
    bit          m_pend_br;
    int          m_cnt;
    bit          m_trap;
    logic [31:0] pc_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_first     = 1;
        m_have_pend = 0;
        m_pend_tgt  = '0;
        m_pend_br   = 0;
        m_cnt       = 0;
        m_trap      = 0;
        pc_reg      = RESET_PC;
    endtask

    // Called at posedge+1: drive inputs, then settle to mid-cycle.
    task automatic drive(input logic [31:0] pc, input bit ic, input bit dc, input bit hz,
                         input bit br, input logic [31:0] bt, input bit j,
                         input logic [31:0] jt);
        pc_cur_i = pc; icache_stall_i = ic; dcache_stall_i = dc; hazard_i = hz;
        branch_taken_i = br; branch_target_i = bt; jump_i = j; jump_target_i = jt;
        #4;
    endtask

    // Compare all outputs with the model, advance the model, cross the edge.
    task automatic tick();
        bit          stall, applied, e_wr, e_fi, e_fd, e_trap;
        logic [31:0] e_next, tgt;
        stall   = icache_stall_i | dcache_stall_i | hazard_i;
        e_next  = pc_cur_i;
        e_wr    = 0; e_fi = 0; e_fd = 0; applied = 0; e_trap = 0;
        tgt     = '0;
        check("redirect_cnt", {16'h0, redirect_cnt_o}, m_cnt);
        check("trap", {31'h0, trap_o}, {31'h0, m_trap});
        if (m_first) begin
            e_next = RESET_PC;
            e_wr   = 1;
        end else if (!m_have_pend) begin
            if (branch_taken_i) begin
                e_fi = 1; e_fd = 1; tgt = branch_target_i;
            end else if (jump_i) begin
                e_fi = 1; tgt = jump_target_i;
            end
            if (!stall) begin
                e_wr = 1;
                if (branch_taken_i || jump_i) applied = 1;
                else e_next = pc_cur_i + 32'd4;
            end else if (branch_taken_i || jump_i) begin
                m_have_pend = 1; m_pend_tgt = tgt; m_pend_br = branch_taken_i;
            end
        end else if (stall) begin
            if (branch_taken_i && !m_pend_br) begin
                m_pend_tgt = branch_target_i; m_pend_br = 1; e_fi = 1; e_fd = 1;
            end
        end else begin
            e_wr = 1; applied = 1; m_have_pend = 0;
            if (branch_taken_i) begin
                tgt = branch_target_i; e_fi = 1; e_fd = 1;
            end else begin
                tgt = m_pend_tgt;
            end
        end
        if (applied) begin
`ifdef PC_ALIGN_TRAP_EN
            if (tgt % 4 != 0) begin
                e_next = TRAP_VEC; e_trap = 1;
            end else begin
                e_next = tgt;
            end
`else
            e_next = tgt - (tgt % 4);
`endif
        end
        check("pc_next", pc_next_o, e_next);
        check("pc_write", {31'h0, pc_write_o}, {31'h0, e_wr});
        check("flush_if", {31'h0, flush_if_o}, {31'h0, e_fi});
        check("flush_id", {31'h0, flush_id_o}, {31'h0, e_fd});
        if (applied && m_cnt < 65535) m_cnt++;
        m_trap  = e_trap;
        m_first = 0;
        if (e_wr) pc_reg = e_next;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_pc_next", pc_next_o, RESET_PC);
        check("rst_pc_write", {31'h0, pc_write_o}, 32'h0);
        check("rst_cnt", {16'h0, redirect_cnt_o}, 32'h0);
        check("rst_flush", {30'h0, flush_if_o, flush_id_o}, 32'h0);
        check("rst_trap", {31'h0, trap_o}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit          ic, dc, hz, br, j;
        logic [31:0] bt, jt;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_dut();

        // Reset release and sequential fetch.
        drive(32'h10, 0, 0, 0, 0, 0, 0, 0);
        check("first_pc", pc_next_o, RESET_PC);
        check("first_write", {31'h0, pc_write_o}, 32'h1);
        tick();
        drive(32'h10, 0, 0, 0, 0, 0, 0, 0);
        check("seq_pc", pc_next_o, 32'h14);
        tick();

        // Branch beats jump.
        drive(32'h14, 0, 0, 0, 1, 32'h200, 1, 32'h300);
        check("br_jmp_pc", pc_next_o, 32'h200);
        check("br_jmp_flush", {30'h0, flush_if_o, flush_id_o}, 32'h3);
        tick();
        drive(32'h200, 0, 0, 0, 0, 0, 0, 0);
        check("br_jmp_cnt", {16'h0, redirect_cnt_o}, 32'h1);
        tick();

        // Jump held across a 5-cycle I-cache miss.
        drive(32'h204, 1, 0, 0, 0, 0, 1, 32'h80);
        check("hold_cap_write", {31'h0, pc_write_o}, 32'h0);
        check("hold_cap_flush", {30'h0, flush_if_o, flush_id_o}, 32'h2);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(32'h204, 1, 0, 0, 0, 0, 0, 0);
            check("hold_write", {31'h0, pc_write_o}, 32'h0);
            check("hold_flush", {30'h0, flush_if_o, flush_id_o}, 32'h0);
            tick();
        end
        drive(32'h204, 0, 0, 0, 0, 0, 0, 0);
        check("replay_pc", pc_next_o, 32'h80);
        check("replay_write", {31'h0, pc_write_o}, 32'h1);
        tick();

        // Branch overrides a pending jump; a later jump in HOLD is ignored.
        drive(32'h80, 1, 0, 0, 0, 0, 1, 32'h80);
        tick();
        drive(32'h80, 0, 1, 0, 1, 32'h400, 0, 0);
        check("ovr_flush", {30'h0, flush_if_o, flush_id_o}, 32'h3);
        tick();
        drive(32'h80, 0, 0, 1, 0, 0, 1, 32'h500);
        check("ovr_jmp_flush", {30'h0, flush_if_o, flush_id_o}, 32'h0);
        tick();
        drive(32'h80, 0, 0, 0, 0, 0, 0, 0);
        check("ovr_pc", pc_next_o, 32'h400);
        tick();

        // Wrap-around.
        drive(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc", pc_next_o, 32'h0);
        tick();

        // Misaligned branch target.
        drive(32'h0, 0, 0, 0, 1, 32'h102, 0, 0);
`ifdef PC_ALIGN_TRAP_EN
        check("mis_pc", pc_next_o, TRAP_VEC);
`else
        check("mis_pc", pc_next_o, 32'h100);
`endif
        tick();
        drive(32'h100, 0, 0, 0, 0, 0, 0, 0);
`ifdef PC_ALIGN_TRAP_EN
        check("mis_trap", {31'h0, trap_o}, 32'h1);
`else
        check("mis_trap", {31'h0, trap_o}, 32'h0);
`endif
        tick();

        // Reset mid-HOLD drops the parked redirect.
        drive(32'h104, 1, 0, 0, 0, 0, 1, 32'h80);
        tick();
        drive(32'h104, 1, 0, 0, 0, 0, 0, 0);
        reset_dut();
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_pc", pc_next_o, RESET_PC);
        check("post_rst_write", {31'h0, pc_write_o}, 32'h1);
        tick();
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_seq", pc_next_o, 32'h44);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            ic = ($urandom_range(0, 3) == 0);
            dc = ($urandom_range(0, 7) == 0);
            hz = ($urandom_range(0, 7) == 0);
            br = ($urandom_range(0, 4) == 0);
            j  = ($urandom_range(0, 3) == 0);
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            drive(pc_reg, ic, dc, hz, br, bt, j, jt);
            tick();
        end

        // Counter saturation: a taken branch every cycle.
        for (int c = 0; c < 65600; c++) begin
            drive(pc_reg, 0, 0, 0, 1, {$urandom_range(0, 255), 2'b00}, 0, 0);
            tick();
        end
        drive(pc_reg, 0, 0, 0, 1, 32'h10, 0, 0);
        check("sat_cnt", {16'h0, redirect_cnt_o}, 32'hFFFF);
        tick();
        drive(pc_reg, 0, 0, 0, 0, 0, 0, 0);
        check("sat_cnt_hold", {16'h0, redirect_cnt_o}, 32'hFFFF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
